// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves one GROUP-bit lookahead block; the carry is registered between stages.
module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / GROUP;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign b_eff    = sub ? ~b : b;
   assign cin_eff  = sub | cin;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int HI = (k + 1) * GROUP;

      logic [GROUP-1:0] ga, gb, gg, gp, gs;
      logic [GROUP:0]   gc;
      logic             gci, v_s, c_d;
      logic [HI-1:0]    s_d;
      logic             v_q, c_q;
      logic [HI-1:0]    s_q;

      if (k == 0) begin : src
         assign ga  = a[GROUP-1:0];
         assign gb  = b_eff[GROUP-1:0];
         assign gci = cin_eff;
         assign v_s = in_valid;
         assign s_d = gs;
      end else begin : src
         assign ga  = stg[k-1].up.a_q[GROUP-1:0];
         assign gb  = stg[k-1].up.b_q[GROUP-1:0];
         assign gci = stg[k-1].c_q;
         assign v_s = stg[k-1].v_q;
         // finished low slices ride along so the sum leaves aligned
         assign s_d = {gs, stg[k-1].s_q};
      end

      assign gg  = ga & gb;
      assign gp  = ga ^ gb;
      assign c_d = gc[GROUP];

      // Flat sum-of-products carry per bit: every carry depends only on g, p and the group carry-in.
      always_comb begin
         logic t;
         logic acc;
         t   = 1'b0;
         acc = 1'b0;
         gc  = '0;
         gc[0] = gci;
         for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
               t = gg[j];
               for (int m = j + 1; m <= i; m++) t = t & gp[m];
               acc = acc | t;
            end
            t = gci;
            for (int m = 0; m <= i; m++) t = t & gp[m];
            gc[i+1] = acc | t;
         end
         gs = gp ^ gc[GROUP-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_s;
            if (v_s) begin
               c_q <= c_d;
               s_q <= s_d;
            end
         end
      end

      if (k < STAGES - 1) begin : up
         localparam int UW = WIDTH - HI;
         logic [UW-1:0] a_d, b_d, a_q, b_q;
         if (k == 0) begin : sel
            assign a_d = a[WIDTH-1:GROUP];
            assign b_d = b_eff[WIDTH-1:GROUP];
         end else begin : sel
            assign a_d = stg[k-1].up.a_q[UW+GROUP-1:GROUP];
            assign b_d = stg[k-1].up.b_q[UW+GROUP-1:GROUP];
         end
         always_ff @(posedge clk) begin
            if (advance && v_s) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      if (k == STAGES - 1) begin : fin
         logic cm_q;
         always_ff @(posedge clk) begin
            if (rst) cm_q <= 1'b0;
            else if (advance && v_s) cm_q <= gc[GROUP-1];
         end
      end
   end

   assign out_valid = stg[STAGES-1].v_q;
   assign sum       = stg[STAGES-1].s_q;
   assign cout      = stg[STAGES-1].c_q;
   assign ovf       = stg[STAGES-1].c_q ^ stg[STAGES-1].fin.cm_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 16/4 instance and a 4/4 single-stage instance,
// checked against a behavioural add/subtract model through expected/observed queues.
module tb_pipelined_cla_adder;
   localparam int LAT16 = 3;
   localparam int LAT4  = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic        iv16, ir16, ov16, ordy16, cin16, sub16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;
   logic        iv4, ir4, ov4, ordy4, cin4, sub4, cout4, ovf4;
   logic [3:0]  a4, b4, sum4;
   logic        acc16, acc4;

   exp_t exp16[$], obs16[$], exp4[$], obs4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) d16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16),
      .sum(sum16), .cout(cout16), .ovf(ovf16));

   pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) d4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(ordy4),
      .sum(sum4), .cout(cout4), .ovf(ovf4));

   function automatic exp_t model(int w, logic [15:0] x, logic [15:0] y, logic ci, logic sb, int c);
      exp_t        r;
      logic [16:0] t;
      logic [15:0] m, yy;
      m     = 16'((32'd1 << w) - 32'd1);
      yy    = (sb ? ~y : y) & m;
      t     = {1'b0, x & m} + {1'b0, yy} + {16'd0, sb | ci};
      r.sum = t[15:0] & m;
      r.cout = t[w];
      r.ovf = (x[w-1] == yy[w-1]) && (r.sum[w-1] != x[w-1]);
      r.cyc = c;
      return r;
   endfunction

   function automatic exp_t mk(logic [15:0] s, logic c, logic v, int t);
      exp_t r;
      r.sum = s; r.cout = c; r.ovf = v; r.cyc = t;
      return r;
   endfunction

   // One clock: record handshakes seen just before the edge, then step past it.
   task automatic step();
      @(negedge clk);
      acc16 = iv16 && ir16 && !rst;
      acc4  = iv4 && ir4 && !rst;
      if (ov16 && ordy16 && !rst) obs16.push_back(mk(sum16, cout16, ovf16, cyc));
      if (ov4 && ordy4 && !rst) obs4.push_back(mk({12'd0, sum4}, cout4, ovf4, cyc));
      if (rst) begin
         exp16.delete();
         exp4.delete();
      end
      if (acc16) exp16.push_back(model(16, a16, b16, cin16, sub16, cyc + 1));
      if (acc4) exp4.push_back(model(4, {12'd0, a4}, {12'd0, b4}, cin4, sub4, cyc + 1));
      @(posedge clk);
      #1;
   endtask

   task automatic send16(logic [15:0] x, logic [15:0] y, logic ci, logic sb);
      iv16 = 1'b1; a16 = x; b16 = y; cin16 = ci; sub16 = sb;
      acc16 = 1'b0;
      for (int t = 0; t < 50 && !acc16; t++) step();
      if (!acc16) begin
         failures++;
         $display("FAIL send16_timeout in_ready never seen, required 1 within 50 cycles");
      end
   endtask

   task automatic send4(logic [3:0] x, logic [3:0] y, logic ci, logic sb);
      iv4 = 1'b1; a4 = x; b4 = y; cin4 = ci; sub4 = sb;
      acc4 = 1'b0;
      for (int t = 0; t < 50 && !acc4; t++) step();
      if (!acc4) begin
         failures++;
         $display("FAIL send4_timeout in_ready never seen, required 1 within 50 cycles");
      end
   endtask

   task automatic drain(int n);
      iv16 = 1'b0;
      iv4  = 1'b0;
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; ordy16 = 1'b0; ordy4 = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (ov16 !== 1'b0 || ov4 !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b/%b want=0/0", ov16, ov4);
      end
      checks++;
      if (sum16 !== 16'h0 || sum4 !== 4'h0) begin
         failures++; $display("FAIL reset_sum got=%h/%h want=0/0", sum16, sum4);
      end
      checks++;
      if ({cout16, ovf16, cout4, ovf4} !== 4'b0) begin
         failures++; $display("FAIL reset_flags got=%b want=0000", {cout16, ovf16, cout4, ovf4});
      end
      checks++;
      if (ir16 !== 1'b1 || ir4 !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b/%b want=1/1", ir16, ir4);
      end
      ordy16 = 1'b1; ordy4 = 1'b1;
   endtask

   task automatic test_add();
      exp_t e, o;
      exp16.delete(); obs16.delete();
      send16(16'h00FF, 16'h0001, 1'b0, 1'b0);
      send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send16(16'h1234, 16'h4321, 1'b1, 1'b0);
      send16(16'h8000, 16'h8000, 1'b1, 1'b0);
      drain(8);
      checks++;
      if (obs16.size() != exp16.size()) begin
         failures++; $display("FAIL add_count got=%0d want=%0d", obs16.size(), exp16.size());
      end
      while (exp16.size() != 0 && obs16.size() != 0) begin
         e = exp16.pop_front(); o = obs16.pop_front();
         checks++;
         if ({o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
            failures++;
            $display("FAIL add_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
         end
         checks++;
         if (o.cyc - e.cyc != LAT16) begin
            failures++; $display("FAIL add_latency got=%0d want=%0d", o.cyc - e.cyc, LAT16);
         end
      end
   endtask

   task automatic test_sub();
      exp_t e, o;
      exp16.delete(); obs16.delete();
      send16(16'd5, 16'd7, 1'b1, 1'b1);
      send16(16'h8000, 16'h0001, 1'b0, 1'b1);
      send16(16'd7, 16'd5, 1'b0, 1'b1);
      send16(16'h0000, 16'h0000, 1'b1, 1'b1);
      send16(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
      drain(8);
      checks++;
      if (obs16.size() != exp16.size()) begin
         failures++; $display("FAIL sub_count got=%0d want=%0d", obs16.size(), exp16.size());
      end
      while (exp16.size() != 0 && obs16.size() != 0) begin
         e = exp16.pop_front(); o = obs16.pop_front();
         checks++;
         if ({o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
            failures++;
            $display("FAIL sub_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     o.sum, o.cout, o.ovf, e.sum, e.cout, e.ovf);
         end
         checks++;
         if (o.cyc - e.cyc != LAT16) begin
            failures++; $display("FAIL sub_latency got=%0d want=%0d", o.cyc - e.cyc, LAT16);
         end
      end
   endtask

   task automatic test_stall();
      exp_t        e, o;
      int          i, k;
      bit          started;
      logic [15:0] held;
      exp16.delete(); obs16.delete();
      i = 1; started = 1'b0; held = '0;
      iv16 = 1'b1; a16 = 16'd1; b16 = 16'd100; cin16 = 1'b0; sub16 = 1'b0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (acc16) i++;
         iv16 = (i <= 8); a16 = 16'(i); b16 = 16'(100 * i);
         if (!started && ov16 === 1'b1) begin
            started = 1'b1; held = sum16; ordy16 = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               if (acc16) i++;
               checks++;
               if (ir16 !== 1'b0 || ov16 !== 1'b1 || sum16 !== held) begin
                  failures++;
                  $display("FAIL stall_hold cyc%0d got in_ready=%b out_valid=%b sum=%h want 0/1/%h",
                           s, ir16, ov16, sum16, held);
               end
            end
            ordy16 = 1'b1;
         end
      end
      iv16 = 1'b0;
      checks++;
      if (obs16.size() != 8 || exp16.size() != 8) begin
         failures++;
         $display("FAIL stall_count got=%0d accepted=%0d want=8", obs16.size(), exp16.size());
      end
      k = 1;
      while (exp16.size() != 0 && obs16.size() != 0) begin
         e = exp16.pop_front(); o = obs16.pop_front();
         checks++;
         if (o.sum !== 16'(101 * k) || {o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
            failures++;
            $display("FAIL stall_order beat%0d got sum=%h want sum=%h", k, o.sum, 16'(101 * k));
         end
         k++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e, o;
      exp16.delete(); obs16.delete();
      send16(16'h1111, 16'h0001, 1'b0, 1'b0);
      send16(16'h2222, 16'h0002, 1'b0, 1'b0);
      send16(16'h3333, 16'h0003, 1'b0, 1'b0);
      a16 = 16'hAAAA; b16 = 16'h5555; iv16 = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; iv16 = 1'b0;
      checks++;
      if (ov16 !== 1'b0) begin
         failures++; $display("FAIL rstmid_out_valid got=%b want=0", ov16);
      end
      for (int t = 0; t < 8; t++) begin
         step();
         checks++;
         if (ov16 !== 1'b0) begin
            failures++; $display("FAIL rstmid_stale cyc%0d got out_valid=%b want=0", t, ov16);
         end
      end
      send16(16'h0123, 16'h0456, 1'b0, 1'b0);
      drain(8);
      checks++;
      if (obs16.size() != 1 || exp16.size() != 1) begin
         failures++;
         $display("FAIL rstmid_count got=%0d accepted=%0d want=1", obs16.size(), exp16.size());
      end
      while (exp16.size() != 0 && obs16.size() != 0) begin
         e = exp16.pop_front(); o = obs16.pop_front();
         checks++;
         if ({o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
            failures++; $display("FAIL rstmid_result got sum=%h want sum=%h", o.sum, e.sum);
         end
         checks++;
         if (o.cyc - e.cyc != LAT16) begin
            failures++; $display("FAIL rstmid_latency got=%0d want=%0d", o.cyc - e.cyc, LAT16);
         end
      end
   endtask

   task automatic test_exhaustive4();
      exp_t e, o;
      exp4.delete(); obs4.delete();
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
               for (int y = 0; y < 16; y++)
                  send4(4'(x), 4'(y), c[0], s[0]);
      drain(4);
      checks++;
      if (obs4.size() != 1024 || exp4.size() != 1024) begin
         failures++;
         $display("FAIL w4_count got=%0d accepted=%0d want=1024", obs4.size(), exp4.size());
      end
      while (exp4.size() != 0 && obs4.size() != 0) begin
         e = exp4.pop_front(); o = obs4.pop_front();
         checks++;
         if ({o.cout, o.sum} !== {e.cout, e.sum}) begin
            failures++; $display("FAIL w4_sum got=%b_%h want=%b_%h", o.cout, o.sum, e.cout, e.sum);
         end
         checks++;
         if (o.ovf !== e.ovf) begin
            failures++; $display("FAIL w4_ovf got=%b want=%b (sum %h)", o.ovf, e.ovf, e.sum);
         end
         checks++;
         if (o.cyc - e.cyc != LAT4) begin
            failures++; $display("FAIL w4_latency got=%0d want=%0d", o.cyc - e.cyc, LAT4);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; ordy4 = 1'b0;
      acc16 = 1'b0; acc4 = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_stall();
      test_reset_mid();
      test_exhaustive4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
